decode_stage: RTL
=================

# decode_stage

Registered RV32 decode stage with a valid/ready elastic buffer, pipeline flush, and optional M-extension and Zicsr/SYSTEM decode. It sits between the fetch stage and the register-read/issue stage. It replaces purely combinational decoding with a stage that holds decoded packets under back-pressure. Illegal-instruction detection covers funct3/funct7 legality, not only the opcode.

## Interface
- `ENABLE_M`, 1: decode MUL/DIV/REM (funct7 = 7'b0000001 on OPCODE_ALU). When 0, these encodings are illegal.
- `ENABLE_ZICSR`, 1: decode CSRRW/S/C and their immediate forms, plus MRET. When 0, only ECALL and EBREAK are legal on OPCODE_SYSTEM.
- `STRICT`, 1: enforce funct7 and funct3 legality. When 0, only unknown opcodes are illegal.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_flush` in 1: squash all held and incoming packets.
- `i_valid` in 1: fetch packet valid.
- `o_ready` out 1: stage can accept a packet.
- `i_instr` in 32: instruction word.
- `i_pc` in 32: PC of `i_instr`.
- `i_fetch_fault` in 1: fetch raised an access fault for this packet.
- `o_valid` out 1: decoded packet valid.
- `i_ready` in 1: downstream accepts the packet.
- `o_out` out instruction_t: decoded packet, extended per Structure.

## Operation
- Transfers:
  - Input transfer occurs when `i_valid & o_ready`.
  - Output transfer occurs when `o_valid & i_ready`.
- Storage: two entries, main (drives `o_out`) and skid. `o_ready` = skid empty, taken directly from a flop.
- Base fields:
  - `rs1_pc`, `rs2_imm`, `branch`, `branch_type`, `jump`, `loadstore`, `load_zeroextend`, `imm`, `alu_op` follow the RV32I rules already used in the codebase.
  - `rd_addr` = 0 for STORE, BRANCH, FENCE, ECALL, EBREAK, MRET and illegal instructions.
  - `rs1_addr` = 0 for LUI.
- `inst_raw` = {1'b1, i_instr}.
- M extension: funct7 = 0000001 on OPCODE_ALU sets `muldiv` = 1 and `muldiv_op` = funct3. `alu_op` is forced to 0.
- SYSTEM:
  - ECALL sets `ecall`; EBREAK sets `ebreak`; MRET sets `mret`.
  - CSR ops set `csr_op` = funct3, `csr_addr` = i_instr[31:20], and `rs2_imm` = 1. For the immediate forms, `imm` = zero-extended rs1 field.
- FENCE and FENCE.I decode as legal no-ops: `rd_addr` = 0, `loadstore` = 0.
- Illegal when `STRICT` = 1:
  - ALU: funct7 not in {0, 0x20 with funct3 ∈ {0,5}, 0x01 if ENABLE_M}.
  - ALUIMM shifts: funct7 not 0, except 0x20 for SRAI.
  - LOAD: funct3 ∉ {0,1,2,4,5}.
  - STORE: funct3 > 2.
  - BRANCH: funct3 ∈ {2,3}.
  - JALR: funct3 ≠ 0.
  - Unknown SYSTEM encodings.
  - Any opcode[1:0] ≠ 2'b11.
- Illegal packets set `inst_invalid` = 1. All side-effect flags (`branch`, `jump`, `loadstore`, `muldiv`, `csr_op`, `ecall`, `ebreak`, `mret`) are cleared on them.
- Fetch fault: sets `fetch_fault` = 1, all side-effect flags = 0, `inst_invalid` = 0. `pc` is preserved.

## Timing
- Reset: `o_valid` = 0, skid empty, `o_ready` = 1 on the first cycle after `i_rst_n` rises. `o_ready` = 0 while `i_rst_n` is low. The contents of `o_out` are don't-care, but `o_out.inst_raw[32]` = 0.
- Latency: 1 cycle. A packet accepted at edge N appears on `o_out` after edge N.
- Throughput: 1 packet/cycle while `i_ready` is high.
- Stall: if main is full and not draining when an input transfer occurs, the packet goes to skid and `o_ready` drops the next cycle.
- Skid drain: when main drains, skid moves to main and `o_ready` returns to 1 the next cycle.
- Ordering is strictly FIFO. No packet is duplicated or lost without a flush.
- Simultaneous input and output transfer with skid empty: main is replaced in place.
- Flush: at the edge where `i_flush` is sampled high, main and skid are both cleared. Any input transfer in that same cycle is discarded. `o_valid` = 0 the next cycle. Flush has priority over everything except reset.
- Reset mid-stall: all packets are dropped and there is no output transfer.
- `o_out` must remain stable while `o_valid & !i_ready`.

## Structure
- Shared package `decode_pkg`:
  - Extend instruction_t with `muldiv`, `muldiv_op[2:0]`, `csr_op[2:0]`, `csr_addr[11:0]`, `ecall`, `ebreak`, `mret`, `fetch_fault`.
  - Add `OPCODE_SYSTEM`, `OPCODE_MISC_MEM`, `FUNCT7_MULDIV`, `FUNCT7_ALT`, and CSR funct3 constants alongside the existing `OPCODE_*`/`ALU_*` defines.
- Sub-module `decode_fields`: purely combinational, maps (instr, pc, fault, params) to instruction_t. `decode_stage` contains only the elastic buffer and control around it.

## Test plan
- 0x002081B3 (ADD x3,x1,x2) at pc 0x100 with `i_ready` = 1 → the next cycle gives `o_valid` = 1, `alu_op` = 0, `rd` = 3, `rs1` = 1, `rs2` = 2, `rs2_imm` = 0, `pc` = 0x100.
- 0x022081B3 (MUL x3,x1,x2): with ENABLE_M = 1 → `muldiv` = 1, `muldiv_op` = 0. With ENABLE_M = 0 → `inst_invalid` = 1, `rd` = 0.
- 0x300110F3 (CSRRW x1,mstatus,x2) → `csr_op` = 1, `csr_addr` = 0x300, `rd` = 1. 0x00000073 → `ecall` = 1, `rd` = 0.
- 0x00013083 (LD) → `inst_invalid` = 1, `loadstore` = 0. Same word with `i_fetch_fault` = 1 → `fetch_fault` = 1, `inst_invalid` = 0.
- Back-pressure: stream 8 sequential ADDs with `i_ready` toggling randomly → `o_ready` drops only when the skid is full, and all 8 emerge in order with correct PCs.
- Assert `i_flush` with main and skid full and `i_valid` high → `o_valid` = 0 and `o_ready` = 1 the next cycle, and no flushed PC ever appears at the output.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32 opcode/ALU/CSR constants and the decoded packet type
package decode_pkg;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_ALUIMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_ALU      = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_PRIV = 3'b000;
  localparam logic [2:0] CSR_RW      = 3'b001;
  localparam logic [2:0] CSR_RS      = 3'b010;
  localparam logic [2:0] CSR_RC      = 3'b011;
  localparam logic [2:0] CSR_RWI     = 3'b101;
  localparam logic [2:0] CSR_RSI     = 3'b110;
  localparam logic [2:0] CSR_RCI     = 3'b111;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;

  // ALU op encoding is {alt, funct3} so register and immediate forms share it
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hd;

  typedef struct packed {
    logic [32:0] inst_raw;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        rs1_pc;
    logic        rs2_imm;
    logic        branch;
    logic [2:0]  branch_type;
    logic        jump;
    logic        loadstore;
    logic        load_zeroextend;
    logic        inst_invalid;
    logic        muldiv;
    logic [2:0]  muldiv_op;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        fetch_fault;
  } instruction_t;

  function automatic logic [3:0] alu_op_of(input logic alt, input logic [2:0] funct3);
    case ({alt, funct3})
      4'b0_000: alu_op_of = ALU_ADD;
      4'b1_000: alu_op_of = ALU_SUB;
      4'b0_001: alu_op_of = ALU_SLL;
      4'b0_010: alu_op_of = ALU_SLT;
      4'b0_011: alu_op_of = ALU_SLTU;
      4'b0_100: alu_op_of = ALU_XOR;
      4'b0_101: alu_op_of = ALU_SRL;
      4'b1_101: alu_op_of = ALU_SRA;
      4'b0_110: alu_op_of = ALU_OR;
      4'b0_111: alu_op_of = ALU_AND;
      default:  alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational RV32I/M/Zicsr field decode with legality checks
module decode_fields
  import decode_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1,
  parameter bit STRICT       = 1'b1
) (
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic         fault,
  output instruction_t out
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;
  instruction_t d;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    d          = '0;
    illegal    = 1'b0;
    d.inst_raw = {1'b1, instr};
    d.pc       = pc;
    d.rd_addr  = rd;
    d.rs1_addr = rs1;
    d.rs2_addr = rs2;
    case (opcode)
      OPCODE_LUI: begin
        d.rs1_addr = '0;
        d.rs2_imm  = 1'b1;
        d.imm      = imm_u;
      end
      OPCODE_AUIPC: begin
        d.rs1_pc  = 1'b1;
        d.rs2_imm = 1'b1;
        d.imm     = imm_u;
      end
      OPCODE_JAL: begin
        d.rs1_pc  = 1'b1;
        d.rs2_imm = 1'b1;
        d.jump    = 1'b1;
        d.imm     = imm_j;
      end
      OPCODE_JALR: begin
        d.rs2_imm = 1'b1;
        d.jump    = 1'b1;
        d.imm     = imm_i;
        illegal   = STRICT && (funct3 != 3'b000);
      end
      OPCODE_BRANCH: begin
        d.branch      = 1'b1;
        d.branch_type = funct3;
        d.imm         = imm_b;
        d.alu_op      = ALU_SUB;
        d.rd_addr     = '0;
        illegal       = STRICT && (funct3[2:1] == 2'b01);
      end
      OPCODE_LOAD: begin
        d.loadstore       = 1'b1;
        d.rs2_imm         = 1'b1;
        d.imm             = imm_i;
        d.load_zeroextend = funct3[2];
        illegal           = STRICT && (funct3 == 3'b011 || funct3[2:1] == 2'b11);
      end
      OPCODE_STORE: begin
        d.loadstore = 1'b1;
        d.rs2_imm   = 1'b1;
        d.imm       = imm_s;
        d.rd_addr   = '0;
        illegal     = STRICT && (funct3 > 3'd2);
      end
      OPCODE_ALUIMM: begin
        d.rs2_imm = 1'b1;
        d.imm     = imm_i;
        d.alu_op  = alu_op_of((funct3 == 3'b101) && instr[30], funct3);
        if (funct3 == 3'b001)
          illegal = STRICT && (funct7 != FUNCT7_BASE);
        else if (funct3 == 3'b101)
          illegal = STRICT && (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
      end
      OPCODE_ALU: begin
        if (funct7 == FUNCT7_MULDIV) begin
          d.muldiv    = ENABLE_M;
          d.muldiv_op = funct3;
          illegal     = !ENABLE_M;
        end else begin
          d.alu_op = alu_op_of(instr[30], funct3);
          illegal  = STRICT && !((funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101)));
        end
      end
      OPCODE_MISC_MEM: d.rd_addr = '0;
      OPCODE_SYSTEM: begin
        case (funct3)
          FUNCT3_PRIV: begin
            d.rd_addr = '0;
            case (instr[31:20])
              SYS_ECALL:  d.ecall  = 1'b1;
              SYS_EBREAK: d.ebreak = 1'b1;
              SYS_MRET: begin
                d.mret  = ENABLE_ZICSR;
                illegal = !ENABLE_ZICSR;
              end
              default: illegal = STRICT;
            endcase
            if (STRICT && (rs1 != 5'd0 || rd != 5'd0)) illegal = 1'b1;
          end
          CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI: begin
            d.csr_op   = ENABLE_ZICSR ? funct3 : 3'b000;
            d.csr_addr = instr[31:20];
            d.rs2_imm  = 1'b1;
            if (funct3[2]) d.imm = {27'b0, rs1};
            illegal    = !ENABLE_ZICSR;
          end
          default: illegal = STRICT || !ENABLE_ZICSR;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // A fetch fault outranks decode legality: the packet carries only the trap cause
    if (fault || illegal) begin
      d.branch       = 1'b0;
      d.jump         = 1'b0;
      d.loadstore    = 1'b0;
      d.muldiv       = 1'b0;
      d.csr_op       = 3'b000;
      d.ecall        = 1'b0;
      d.ebreak       = 1'b0;
      d.mret         = 1'b0;
      d.rd_addr      = '0;
      d.fetch_fault  = fault;
      d.inst_invalid = !fault;
    end
    out = d;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with main/skid elastic buffer and flush
module decode_stage
  import decode_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1,
  parameter bit STRICT       = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  input  logic         i_fetch_fault,
  output logic         o_valid,
  input  logic         i_ready,
  output instruction_t o_out
);

  instruction_t dec, main_q, main_d, skid_q, skid_d;
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d, ready_q;
  logic         in_fire, main_free;

  decode_fields #(
    .ENABLE_M     (ENABLE_M),
    .ENABLE_ZICSR (ENABLE_ZICSR),
    .STRICT       (STRICT)
  ) u_fields (
    .instr (i_instr),
    .pc    (i_pc),
    .fault (i_fetch_fault),
    .out   (dec)
  );

  assign in_fire   = i_valid & ready_q;
  assign main_free = !main_v_q | i_ready;

  // ready_q is low whenever skid is occupied, so a skid entry never coexists with an input transfer
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (i_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= !skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = main_v_q;
  assign o_out   = main_q;

endmodule
